// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data requesters
module mem_port_arbiter #(
  parameter int CORE            = 0,
  parameter int DATA_WIDTH      = 32,
  parameter int ADDRESS_BITS    = 20,
  parameter int STARVE_LIMIT    = 4,
  parameter int SCAN_CYCLES_MIN = 0,
  parameter int SCAN_CYCLES_MAX = 1000
) (
  input  logic                      clock,
  input  logic                      reset,
  // instruction fetch side
  input  logic                      i_read,
  input  logic [ADDRESS_BITS-1:0]   i_address,
  input  logic                      i_flush,
  output logic                      i_ready,
  output logic                      i_valid,
  output logic [DATA_WIDTH-1:0]     i_data,
  output logic [ADDRESS_BITS-1:0]   i_address_out,
  output logic                      i_page_fault,
  output logic                      i_access_fault,
  // data memory side
  input  logic                      d_read,
  input  logic                      d_write,
  input  logic [ADDRESS_BITS-1:0]   d_address,
  input  logic [DATA_WIDTH-1:0]     d_data_in,
  input  logic [DATA_WIDTH/8-1:0]   d_byte_en,
  output logic                      d_ready,
  output logic                      d_valid,
  output logic [DATA_WIDTH-1:0]     d_data_out,
  output logic [ADDRESS_BITS-1:0]   d_address_out,
  output logic                      d_page_fault,
  output logic                      d_access_fault,
  // downstream memory port
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [ADDRESS_BITS-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]     mem_data_out,
  output logic [DATA_WIDTH/8-1:0]   mem_byte_en,
  input  logic                      mem_ready,
  input  logic                      mem_valid,
  input  logic [DATA_WIDTH-1:0]     mem_data_in,
  input  logic                      mem_page_fault,
  input  logic                      mem_access_fault,
  input  logic                      scan
);

  localparam int STREAK_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(STARVE_LIMIT);

  typedef enum logic { S_IDLE, S_WAIT } state_t;
  typedef enum logic { OWN_I, OWN_D } owner_t;

  state_t                    state_q, state_d;
  owner_t                    owner_q, owner_d;
  logic                      store_q, store_d;
  logic                      drop_q, drop_d;
  logic [STREAK_W-1:0]       streak_q, streak_d;
  logic [ADDRESS_BITS-1:0]   addr_q, addr_d;
  logic [31:0]               cycle_q;

  logic d_req, i_req, starve, grant_i, grant_d;

  // Data normally wins; a fetch that has watched STARVE_LIMIT data grants goes first.
  // A flush in IDLE suppresses the fetch request for that cycle.
  assign d_req   = d_read | d_write;
  assign i_req   = i_read & ~i_flush;
  assign starve  = i_req & (streak_q == STREAK_MAX);
  assign grant_i = i_req & (~d_req | starve);
  assign grant_d = d_req & ~grant_i;

  // Next-state and output decode; mem_* and readies are combinational for 0-cycle issue
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    store_d  = store_q;
    drop_d   = drop_q;
    streak_d = streak_q;
    addr_d   = addr_q;

    i_ready        = 1'b0;
    i_valid        = 1'b0;
    i_data         = '0;
    i_address_out  = '0;
    i_page_fault   = 1'b0;
    i_access_fault = 1'b0;
    d_ready        = 1'b0;
    d_valid        = 1'b0;
    d_data_out     = '0;
    d_address_out  = '0;
    d_page_fault   = 1'b0;
    d_access_fault = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_address    = '0;
    mem_data_out   = '0;
    mem_byte_en    = '0;

    case (state_q)
      S_IDLE: begin
        if (grant_d) begin
          mem_read     = d_read;
          mem_write    = d_write;
          mem_address  = d_address;
          mem_data_out = d_data_in;
          mem_byte_en  = d_byte_en;
          if (mem_ready) begin
            d_ready = 1'b1;
            owner_d = OWN_D;
            store_d = d_write;
            addr_d  = d_address;
            state_d = S_WAIT;
            // Count data grants only while a fetch is actually waiting
            if (!i_read)
              streak_d = '0;
            else if (streak_q != STREAK_MAX)
              streak_d = streak_q + STREAK_W'(1);
          end
        end else if (grant_i) begin
          mem_read    = 1'b1;
          mem_address = i_address;
          if (mem_ready) begin
            i_ready  = 1'b1;
            owner_d  = OWN_I;
            store_d  = 1'b0;
            drop_d   = 1'b0;
            addr_d   = i_address;
            state_d  = S_WAIT;
            streak_d = '0;
          end
        end
      end
      S_WAIT: begin
        // A redirect makes the outstanding fetch stale; data accesses are unaffected
        if (owner_q == OWN_I && i_flush)
          drop_d = 1'b1;
        if (mem_valid) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
          if (owner_q == OWN_D) begin
            d_valid        = 1'b1;
            d_data_out     = store_q ? '0 : mem_data_in;
            d_address_out  = addr_q;
            d_page_fault   = mem_page_fault;
            d_access_fault = mem_access_fault;
          end else if (!drop_q && !i_flush) begin
            i_valid        = 1'b1;
            i_data         = mem_data_in;
            i_address_out  = addr_q;
            i_page_fault   = mem_page_fault;
            i_access_fault = mem_access_fault;
          end
        end
      end
    endcase

    // Outputs are forced quiet for the whole reset interval, not just after the edge
    if (reset) begin
      i_ready        = 1'b0;
      i_valid        = 1'b0;
      i_data         = '0;
      i_address_out  = '0;
      i_page_fault   = 1'b0;
      i_access_fault = 1'b0;
      d_ready        = 1'b0;
      d_valid        = 1'b0;
      d_data_out     = '0;
      d_address_out  = '0;
      d_page_fault   = 1'b0;
      d_access_fault = 1'b0;
      mem_read       = 1'b0;
      mem_write      = 1'b0;
      mem_address    = '0;
      mem_data_out   = '0;
      mem_byte_en    = '0;
    end
  end

  // State, ownership, flush-drop, starvation and cycle registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= OWN_I;
      store_q  <= 1'b0;
      drop_q   <= 1'b0;
      streak_q <= '0;
      addr_q   <= '0;
      cycle_q  <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      store_q  <= store_d;
      drop_q   <= drop_d;
      streak_q <= streak_d;
      addr_q   <= addr_d;
      cycle_q  <= cycle_q + 32'd1;
    end
  end

`ifndef SYNTHESIS
  localparam logic signed [32:0] SCAN_LO = 33'(SCAN_CYCLES_MIN);
  localparam logic signed [32:0] SCAN_HI = 33'(SCAN_CYCLES_MAX);
  logic signed [32:0] cycle_s;
  assign cycle_s = $signed({1'b0, cycle_q});

  // Debug trace of arbiter state inside the configured cycle window
  always_ff @(posedge clock) begin
    if (!reset && scan && cycle_s >= SCAN_LO && cycle_s <= SCAN_HI)
      $display("core %0d cycle %0d state %0d owner %0d drop %0d d_streak %0d",
               CORE, cycle_q, state_q, owner_q, drop_q, streak_q);
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        i_read, i_flush, i_ready, i_valid, i_page_fault, i_access_fault;
  logic [19:0] i_address, i_address_out;
  logic [31:0] i_data;
  logic        d_read, d_write, d_ready, d_valid, d_page_fault, d_access_fault;
  logic [19:0] d_address, d_address_out;
  logic [31:0] d_data_in, d_data_out;
  logic [3:0]  d_byte_en, mem_byte_en;
  logic        mem_read, mem_write, mem_ready, mem_valid, mem_page_fault, mem_access_fault;
  logic [19:0] mem_address;
  logic [31:0] mem_data_out, mem_data_in;
  logic        scan;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .clock(clock), .reset(reset),
    .i_read(i_read), .i_address(i_address), .i_flush(i_flush), .i_ready(i_ready),
    .i_valid(i_valid), .i_data(i_data), .i_address_out(i_address_out),
    .i_page_fault(i_page_fault), .i_access_fault(i_access_fault),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_data_in(d_data_in),
    .d_byte_en(d_byte_en), .d_ready(d_ready), .d_valid(d_valid), .d_data_out(d_data_out),
    .d_address_out(d_address_out), .d_page_fault(d_page_fault), .d_access_fault(d_access_fault),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_data_out(mem_data_out), .mem_byte_en(mem_byte_en), .mem_ready(mem_ready),
    .mem_valid(mem_valid), .mem_data_in(mem_data_in), .mem_page_fault(mem_page_fault),
    .mem_access_fault(mem_access_fault), .scan(scan)
  );

  // ctl: i_read,i_flush,d_read,d_write,mem_ready,mem_valid,mem_pf,mem_af
  localparam logic [7:0] C_IR = 8'h80, C_FL = 8'h40, C_DR = 8'h20, C_DW = 8'h10;
  localparam logic [7:0] C_MR = 8'h08, C_MV = 8'h04, C_PF = 8'h02, C_AF = 8'h01;
  // eflg: i_ready,i_valid,d_ready,d_valid,mem_read,mem_write,i_pf,i_af,d_pf,d_af
  localparam logic [9:0] E_IRDY = 10'h200, E_IVAL = 10'h100, E_DRDY = 10'h080, E_DVAL = 10'h040;
  localparam logic [9:0] E_MRD = 10'h020, E_MWR = 10'h010, E_IPF = 10'h008, E_IAF = 10'h004;
  localparam logic [9:0] E_DPF = 10'h002, E_DAF = 10'h001;

  typedef struct {
    string       nm;
    logic [7:0]  ctl;
    logic [19:0] addr;
    logic [31:0] data;
    logic [9:0]  eflg;
    logic [19:0] eaddr;
    logic [31:0] edata;
  } vec_t;

  typedef struct packed {
    logic        own_i;
    logic [19:0] addr;
    logic [31:0] data;
  } sb_t;

  vec_t vt[$];
  sb_t  sb[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mkv(input string nm, input logic [7:0] ctl, input logic [19:0] addr,
                               input logic [31:0] data, input logic [9:0] eflg,
                               input logic [19:0] eaddr, input logic [31:0] edata);
    vec_t v;
    v.nm = nm; v.ctl = ctl; v.addr = addr; v.data = data;
    v.eflg = eflg; v.eaddr = eaddr; v.edata = edata;
    return v;
  endfunction

  function automatic logic [31:0] all_out();
    return {15'd0, i_ready, i_valid, i_page_fault, i_access_fault, d_ready, d_valid,
            d_page_fault, d_access_fault, mem_read, mem_write, |i_data, |d_data_out,
            |mem_address, |mem_data_out, |mem_byte_en, |i_address_out, |d_address_out};
  endfunction

  function automatic logic [31:0] flags();
    return {22'd0, i_ready, i_valid, d_ready, d_valid, mem_read, mem_write,
            i_page_fault, i_access_fault, d_page_fault, d_access_fault};
  endfunction

  task automatic idle_inputs();
    i_read = 0; i_flush = 0; i_address = '0;
    d_read = 0; d_write = 0; d_address = '0; d_data_in = '0; d_byte_en = '0;
    mem_ready = 0; mem_valid = 0; mem_data_in = '0; mem_page_fault = 0; mem_access_fault = 0;
  endtask

  // Called just after a rising edge; returns just after the next one
  task automatic apply(input vec_t v);
    i_read = v.ctl[7]; i_flush = v.ctl[6]; d_read = v.ctl[5]; d_write = v.ctl[4];
    mem_ready = v.ctl[3]; mem_valid = v.ctl[2]; mem_page_fault = v.ctl[1]; mem_access_fault = v.ctl[0];
    i_address = v.addr; d_address = v.addr; d_data_in = v.data; d_byte_en = v.data[3:0];
    mem_data_in = v.data;
    @(negedge clock);
    check({v.nm, ".flags"}, flags(), {22'd0, v.eflg});
    if (v.eflg[5] | v.eflg[4]) check({v.nm, ".mem_address"}, {12'd0, mem_address}, {12'd0, v.eaddr});
    else if (v.eflg[8])        check({v.nm, ".i_address_out"}, {12'd0, i_address_out}, {12'd0, v.eaddr});
    else if (v.eflg[6])        check({v.nm, ".d_address_out"}, {12'd0, d_address_out}, {12'd0, v.eaddr});
    if (v.eflg[4]) begin
      check({v.nm, ".mem_data_out"}, mem_data_out, v.edata);
      check({v.nm, ".mem_byte_en"}, {28'd0, mem_byte_en}, {28'd0, v.data[3:0]});
    end
    if (v.eflg[8] && v.eflg[3:2] == 2'b00) check({v.nm, ".i_data"}, i_data, v.edata);
    if (v.eflg[6] && v.eflg[1:0] == 2'b00) check({v.nm, ".d_data_out"}, d_data_out, v.edata);
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    check("reset_outputs", all_out(), 32'd0);
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] resp_addr;
    int ms;
    scan = 1'b0;
    idle_inputs();
    reset = 1'b1;
    i_read = 1; d_read = 1; mem_ready = 1; mem_valid = 1; mem_data_in = 32'hFFFF_FFFF;
    i_address = 20'h10; d_address = 20'h20;
    #3;
    check("reset_hold_outputs", all_out(), 32'd0);
    idle_inputs();
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    // ---------------- table-driven vectors ----------------
    vt.push_back(mkv("fetch_issue",      C_IR|C_MR,       20'h10,  32'h0,        E_IRDY|E_MRD, 20'h10,  32'h0));
    vt.push_back(mkv("fetch_wait",       8'h00,           20'h0,   32'h0,        10'h0,        20'h0,   32'h0));
    vt.push_back(mkv("fetch_resp",       C_MV,            20'h0,   32'h13,       E_IVAL,       20'h10,  32'h13));
    vt.push_back(mkv("idle_stray_valid", C_MV,            20'h0,   32'hBAD,      10'h0,        20'h0,   32'h0));
    vt.push_back(mkv("load_issue",       C_DR|C_MR,       20'h200, 32'h0,        E_DRDY|E_MRD, 20'h200, 32'h0));
    vt.push_back(mkv("load_acc_fault",   C_MV|C_AF,       20'h0,   32'h55,       E_DVAL|E_DAF, 20'h200, 32'h0));
    vt.push_back(mkv("fetch_after_flt",  C_IR|C_MR,       20'h44,  32'h0,        E_IRDY|E_MRD, 20'h44,  32'h0));
    vt.push_back(mkv("fetch_page_fault", C_MV|C_PF,       20'h0,   32'h66,       E_IVAL|E_IPF, 20'h44,  32'h0));
    vt.push_back(mkv("store_issue",      C_DW|C_MR,       20'h300, 32'hDEADBEEF, E_DRDY|E_MWR, 20'h300, 32'hDEADBEEF));
    vt.push_back(mkv("store_ack",        C_MV,            20'h0,   32'h12345678, E_DVAL,       20'h300, 32'h0));
    vt.push_back(mkv("bp_stall0",        C_DW,            20'h304, 32'hCAFE0005, E_MWR,        20'h304, 32'hCAFE0005));
    vt.push_back(mkv("bp_stall1",        C_DW,            20'h304, 32'hCAFE0005, E_MWR,        20'h304, 32'hCAFE0005));
    vt.push_back(mkv("bp_stall2",        C_DW,            20'h304, 32'hCAFE0005, E_MWR,        20'h304, 32'hCAFE0005));
    vt.push_back(mkv("bp_issue",         C_DW|C_MR,       20'h304, 32'hCAFE0005, E_DRDY|E_MWR, 20'h304, 32'hCAFE0005));
    vt.push_back(mkv("bp_ack",           C_MV,            20'h0,   32'h1,        E_DVAL,       20'h304, 32'h0));
    vt.push_back(mkv("idle_flush_block", C_IR|C_FL|C_MR,  20'h48,  32'h0,        10'h0,        20'h0,   32'h0));
    vt.push_back(mkv("both_data_first",  C_IR|C_DR|C_MR,  20'h500, 32'h0,        E_DRDY|E_MRD, 20'h500, 32'h0));
    vt.push_back(mkv("both_wait_resp",   C_IR|C_MV,       20'h504, 32'h77,       E_DVAL,       20'h500, 32'h77));
    foreach (vt[k]) apply(vt[k]);

    // ---------------- starvation bound with scoreboard ----------------
    do_reset();
    ms = 0;
    for (int k = 0; k < 12; k++) begin
      sb_t e;
      logic exp_i;
      exp_i = (ms == 4);
      ms = exp_i ? 0 : ms + 1;
      idle_inputs();
      i_read = 1; d_read = 1; mem_ready = 1;
      i_address = 20'h1000 + 20'(k);
      d_address = 20'h2000 + 20'(k);
      e.own_i = exp_i;
      e.addr  = exp_i ? i_address : d_address;
      e.data  = 32'hC0D0_0000 | {12'd0, e.addr};
      sb.push_back(e);
      @(negedge clock);
      check($sformatf("starve_grant%0d", k), {30'd0, i_ready, d_ready}, exp_i ? 32'd2 : 32'd1);
      resp_addr = mem_address;
      @(posedge clock); #1;
      mem_valid = 1; mem_ready = 1;
      mem_data_in = 32'hC0D0_0000 | {12'd0, resp_addr};
      @(negedge clock);
      check($sformatf("starve_wait_ready%0d", k), {30'd0, i_ready, d_ready}, 32'd0);
      if ((i_valid | d_valid) && sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("sb_owner%0d", k), {30'd0, i_valid, d_valid}, e.own_i ? 32'd2 : 32'd1);
        check($sformatf("sb_addr%0d", k), {12'd0, (i_valid ? i_address_out : d_address_out)}, {12'd0, e.addr});
        check($sformatf("sb_data%0d", k), i_valid ? i_data : d_data_out, e.data);
      end else begin
        check($sformatf("sb_resp_present%0d", k), 32'd0, 32'd1);
      end
      @(posedge clock); #1;
    end
    check("sb_empty", sb.size(), 32'd0);

    // ---------------- flush during fetch ----------------
    do_reset();
    apply(mkv("fl_issue",       C_IR|C_MR, 20'h60, 32'h0,  E_IRDY|E_MRD, 20'h60, 32'h0));
    apply(mkv("fl_flush",       C_FL,      20'h0,  32'h0,  10'h0,        20'h0,  32'h0));
    apply(mkv("fl_dropped",     C_MV,      20'h0,  32'h99, 10'h0,        20'h0,  32'h0));
    apply(mkv("fl_next_issue",  C_IR|C_MR, 20'h64, 32'h0,  E_IRDY|E_MRD, 20'h64, 32'h0));
    apply(mkv("fl_next_resp",   C_MV,      20'h0,  32'hAB, E_IVAL,       20'h64, 32'hAB));
    // flush must not disturb an outstanding data access
    apply(mkv("fl_load_issue",  C_DR|C_MR, 20'h90, 32'h0,  E_DRDY|E_MRD, 20'h90, 32'h0));
    apply(mkv("fl_load_flush",  C_FL,      20'h0,  32'h0,  10'h0,        20'h0,  32'h0));
    apply(mkv("fl_load_resp",   C_FL|C_MV, 20'h0,  32'h5A, E_DVAL,       20'h90, 32'h5A));

    // ---------------- reset mid-transaction ----------------
    apply(mkv("rst_load_issue", C_DR|C_MR, 20'h700, 32'h0, E_DRDY|E_MRD, 20'h700, 32'h0));
    #2;
    reset = 1'b1;
    i_read = 1; d_read = 1; mem_ready = 1; mem_valid = 1; mem_data_in = 32'hFFFF_FFFF;
    i_address = 20'h80; d_address = 20'h84;
    #1;
    check("rst_async_outputs", all_out(), 32'd0);
    @(posedge clock); #3;
    idle_inputs();
    reset = 1'b0;
    mem_valid = 1; mem_data_in = 32'h1234;
    @(negedge clock);
    check("rst_late_resp_ignored", all_out(), 32'd0);
    @(posedge clock); #1;
    apply(mkv("rst_post_issue", C_IR|C_MR, 20'h80, 32'h0,  E_IRDY|E_MRD, 20'h80, 32'h0));
    apply(mkv("rst_post_resp",  C_MV,      20'h0,  32'h42, E_IVAL,       20'h80, 32'h42));

    idle_inputs();
    @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
